// File: rtl/clk_stop_pkg.sv
// Shared types and helpers for the multi-lane edge-clock stop controller.
package clk_stop_pkg;

  localparam int SYNC_DEFAULT = 2;

  typedef enum logic [1:0] {
    STOP      = 2'd0,
    WAIT_SLOT = 2'd1,
    IDLE      = 2'd2
  } lane_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/clk_stop_lane.sv
// One stop lane: datapath-reset resync, rotating release phase, stop FSM
// with minimum hold, and a rising/falling-edge selectable output gate.
module clk_stop_lane
  import clk_stop_pkg::*;
#(
  parameter int REF_DIV     = 2,
  parameter int MIN_STOP    = 4,
  parameter int SYNC_STAGES = SYNC_DEFAULT,
  localparam int PW         = clog2(2 * REF_DIV)
) (
  input  logic          eclk,
  input  logic          reset,
  input  logic          lock,
  input  logic          pll_stop_s,
  input  logic          reset_datapath,
  input  logic [PW-2:0] ref_cnt,
  output logic          reset_datapath_out,
  output logic          stop,
  output logic          stop_busy,
  output logic [PW-1:0] phase
);

  localparam logic [7:0]    HOLD_INIT = 8'(MIN_STOP - 1);
  localparam logic [PW-1:0] PHASE_MAX = PW'(2 * REF_DIV - 1);

  logic [SYNC_STAGES-1:0] rd_sync_reg;
  logic                   rd_last_reg;
  logic                   rd_fall;
  logic [PW-1:0]          phase_reg;

  lane_state_e state_reg, state_next;
  logic [7:0]  hold_reg, hold_next;
  logic        latch_en;
  logic        gate_reg;
  logic        gate_neg_reg;
  logic [PW-2:0] slot_reg;
  logic        edge_sel_reg;

  assign rd_fall = rd_last_reg & ~rd_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge eclk) begin
    if (reset) begin
      rd_sync_reg <= '1;
      rd_last_reg <= 1'b1;
      phase_reg   <= '0;
    end else begin
      rd_sync_reg <= {rd_sync_reg[SYNC_STAGES-2:0], reset_datapath};
      rd_last_reg <= rd_sync_reg[SYNC_STAGES-1];
      if (rd_fall) begin
        phase_reg <= (phase_reg == PHASE_MAX) ? '0 : phase_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    latch_en   = 1'b0;
    unique case (state_reg)
      STOP: begin
        if (hold_reg != 8'd0) begin
          hold_next = hold_reg - 8'd1;
        end
        if (hold_reg == 8'd0 && !pll_stop_s && lock) begin
          state_next = WAIT_SLOT;
          latch_en   = 1'b1;
        end
      end
      WAIT_SLOT: begin
        if (pll_stop_s || !lock) begin
          state_next = STOP;
          hold_next  = HOLD_INIT;
        end else if (ref_cnt == slot_reg) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (pll_stop_s || !lock) begin
          state_next = STOP;
          hold_next  = HOLD_INIT;
        end
      end
      default: begin
        state_next = STOP;
        hold_next  = HOLD_INIT;
      end
    endcase
  end

  // edge_sel only moves on WAIT_SLOT entry, while gate is still high.
  always_ff @(posedge eclk) begin
    if (reset) begin
      state_reg    <= STOP;
      hold_reg     <= HOLD_INIT;
      gate_reg     <= 1'b1;
      slot_reg     <= '0;
      edge_sel_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      gate_reg  <= (state_next != IDLE);
      if (latch_en) begin
        slot_reg     <= phase_reg[PW-1:1];
        edge_sel_reg <= phase_reg[0];
      end
    end
  end

  always_ff @(negedge eclk) begin
    gate_neg_reg <= gate_reg;
  end

  assign stop               = edge_sel_reg ? gate_neg_reg : gate_reg;
  assign stop_busy          = (state_reg != IDLE);
  assign phase              = phase_reg;
  assign reset_datapath_out = rd_sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/clk_stop_mlane.sv
// Multi-lane edge-clock stop controller: shared release reference and
// pll_stop resync feeding LANES independent stop lanes.
module clk_stop_mlane
  import clk_stop_pkg::*;
#(
  parameter int LANES       = 1,
  parameter int REF_DIV     = 2,
  parameter int MIN_STOP    = 4,
  parameter int SYNC_STAGES = SYNC_DEFAULT,
  localparam int PW         = clog2(2 * REF_DIV)
) (
  input  logic                eclk,
  input  logic                reset,
  input  logic                lock,
  input  logic                pll_stop,
  input  logic [LANES-1:0]    reset_datapath,
  output logic [LANES-1:0]    reset_datapath_out,
  output logic [LANES-1:0]    stop,
  output logic [LANES-1:0]    stop_busy,
  output logic [LANES*PW-1:0] phase
);

  localparam int SW = PW - 1;

  logic [SW-1:0]          ref_cnt_reg;
  logic [SYNC_STAGES-1:0] pll_sync_reg;
  logic                   pll_stop_s;

  always_ff @(posedge eclk) begin
    if (reset) begin
      ref_cnt_reg  <= '0;
      pll_sync_reg <= '1;
    end else begin
      ref_cnt_reg  <= (ref_cnt_reg == SW'(REF_DIV - 1)) ? '0 : ref_cnt_reg + 1'b1;
      pll_sync_reg <= {pll_sync_reg[SYNC_STAGES-2:0], pll_stop};
    end
  end

  assign pll_stop_s = pll_sync_reg[SYNC_STAGES-1];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    clk_stop_lane #(
      .REF_DIV     (REF_DIV),
      .MIN_STOP    (MIN_STOP),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_lane (
      .eclk               (eclk),
      .reset              (reset),
      .lock               (lock),
      .pll_stop_s         (pll_stop_s),
      .reset_datapath     (reset_datapath[gi]),
      .ref_cnt            (ref_cnt_reg),
      .reset_datapath_out (reset_datapath_out[gi]),
      .stop               (stop[gi]),
      .stop_busy          (stop_busy[gi]),
      .phase              (phase[gi*PW +: PW])
    );
  end

endmodule

// File: tb/tb_clk_stop_mlane.sv
// Directed bench for clk_stop_mlane: LANES=2, REF_DIV=4, MIN_STOP=4, SYNC_STAGES=2.
module tb_clk_stop_mlane;

  localparam int LANES       = 2;
  localparam int REF_DIV     = 4;
  localparam int MIN_STOP    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int PW          = 3;

  logic             eclk = 1'b0;
  logic             reset = 1'b1;
  logic             lock = 1'b1;
  logic             pll_stop = 1'b0;
  logic [1:0]       reset_datapath = 2'b11;
  logic [1:0]       reset_datapath_out;
  logic [1:0]       stop;
  logic [1:0]       stop_busy;
  logic [2*PW-1:0]  phase;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ref_m = 0;
  int ref_at_edge = 0;
  int n_edges;

  typedef struct {
    logic [1:0]      rd;
    logic [1:0]      exp_rdo;
    logic [2*PW-1:0] exp_phase;
  } rot_vec_t;

  rot_vec_t rot_tab[18];

  always #5 eclk = ~eclk;

  clk_stop_mlane #(
    .LANES       (LANES),
    .REF_DIV     (REF_DIV),
    .MIN_STOP    (MIN_STOP),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .eclk               (eclk),
    .reset              (reset),
    .lock               (lock),
    .pll_stop           (pll_stop),
    .reset_datapath     (reset_datapath),
    .reset_datapath_out (reset_datapath_out),
    .stop               (stop),
    .stop_busy          (stop_busy),
    .phase              (phase)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Independent model of the shared reference counter.
  task automatic tick();
    @(posedge eclk);
    ref_at_edge = ref_m;
    ref_m = reset ? 0 : (ref_m + 1) % REF_DIV;
    #1;
  endtask

  task automatic wait_release(input int lane, input int slot, input bit esel,
                              input int budget, output int edges);
    edges = 0;
    while (stop_busy[lane] !== 1'b0 && edges < budget) begin
      tick();
      edges++;
    end
    if (stop_busy[lane] !== 1'b0) begin
      check($sformatf("release_timeout_l%0d", lane), 32'(stop_busy[lane]), 32'd0);
    end else begin
      check($sformatf("release_ref_l%0d", lane), ref_at_edge, slot);
      if (esel) begin
        check($sformatf("release_half_hi_l%0d", lane), 32'(stop[lane]), 32'd1);
        @(negedge eclk);
        #1;
        check($sformatf("release_half_lo_l%0d", lane), 32'(stop[lane]), 32'd0);
      end else begin
        check($sformatf("release_stop_l%0d", lane), 32'(stop[lane]), 32'd0);
      end
    end
    $display("release lane %0d after %0d edges, ref=%0d stop=%b", lane, edges, ref_at_edge, stop);
  endtask

  task automatic drive_rd(input logic [1:0] rd);
    reset_datapath = rd;
    repeat (SYNC_STAGES + 1) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Lane 1 datapath reset toggles; lane 0 stays high so its phase stays 0.
    for (int k = 0; k < 9; k++) begin
      int ph;
      ph = (k + 1) % (2 * REF_DIV);
      rot_tab[2*k]   = '{rd: 2'b01, exp_rdo: 2'b01, exp_phase: {3'(ph), 3'b000}};
      rot_tab[2*k+1] = '{rd: 2'b11, exp_rdo: 2'b11, exp_phase: {3'(ph), 3'b000}};
    end

    // Reset values
    repeat (3) tick();
    check("rst_stop", stop, 2'b11);
    check("rst_busy", stop_busy, 2'b11);
    check("rst_phase", phase, 6'd0);
    check("rst_rdo", reset_datapath_out, 2'b11);
    $display("reset: stop=%b busy=%b phase=%h rdo=%b", stop, stop_busy, phase, reset_datapath_out);
    reset = 1'b0;
    wait_release(0, 0, 1'b0, 8, n_edges);
    check("rst_release_edges", n_edges, 5);
    check("rst_release_both", stop, 2'b00);

    // MIN_STOP with a one-cycle pll_stop pulse
    pll_stop = 1'b1;
    tick();
    pll_stop = 1'b0;
    check("min_e1", stop, 2'b00);
    tick();
    check("min_e2", stop, 2'b00);
    tick();
    check("min_e3_rise", stop, 2'b11);
    wait_release(0, 0, 1'b0, 12, n_edges);
    check("min_stop_len", 32'(n_edges >= MIN_STOP + 1), 32'd1);
    check("min_release_both", stop, 2'b00);

    // Re-stop during WAIT_SLOT: stop must stay high and hold reloads
    while (ref_m != 2) tick();
    for (int k = 1; k <= 15; k++) begin
      pll_stop = (k == 1 || k == 6);
      tick();
      check($sformatf("restop_e%0d", k), stop, (k >= 3 && k < 15) ? 2'b11 : 2'b00);
    end
    pll_stop = 1'b0;
    check("restop_ref", ref_at_edge, 0);
    $display("restop: released at edge 15, ref=%0d stop=%b", ref_at_edge, stop);

    // Lock drop while IDLE
    lock = 1'b0;
    tick();
    check("lock_drop", stop, 2'b11);
    lock = 1'b1;
    wait_release(0, 0, 1'b0, 12, n_edges);

    // Phase rotation on lane 1
    for (int i = 0; i < 18; i++) begin
      drive_rd(rot_tab[i].rd);
      check($sformatf("rot_rdo_%0d", i), reset_datapath_out, rot_tab[i].exp_rdo);
      check($sformatf("rot_phase_%0d", i), phase, rot_tab[i].exp_phase);
      $display("rotation %0d: rd=%b rdo=%b phase1=%0d phase0=%0d", i, rot_tab[i].rd,
               reset_datapath_out, phase[5:3], phase[2:0]);
    end

    // Lane 0 to phase 3 (slot 1, falling edge), then release half a cycle late
    drive_rd(2'b10);
    drive_rd(2'b11);
    drive_rd(2'b10);
    drive_rd(2'b11);
    drive_rd(2'b10);
    check("half_phase", phase, {3'd1, 3'd3});
    pll_stop = 1'b1;
    tick();
    pll_stop = 1'b0;
    repeat (2) tick();
    check("half_stop_rise", stop, 2'b11);
    wait_release(0, 1, 1'b1, 12, n_edges);

    // Lane 0 to phase 5, reset while waiting for the slot
    drive_rd(2'b11);
    drive_rd(2'b10);
    drive_rd(2'b11);
    drive_rd(2'b10);
    check("midwait_phase", phase, {3'd1, 3'd5});
    while (ref_m != 0) tick();
    pll_stop = 1'b1;
    tick();
    pll_stop = 1'b0;
    repeat (6) tick();
    check("midwait_busy", 32'(stop_busy[0]), 32'd1);
    reset = 1'b1;
    tick();
    check("midwait_rst_stop", stop, 2'b11);
    check("midwait_rst_busy", stop_busy, 2'b11);
    check("midwait_rst_phase", phase, 6'd0);
    check("midwait_rst_rdo", reset_datapath_out, 2'b11);
    $display("midwait reset: stop=%b busy=%b phase=%h", stop, stop_busy, phase);
    tick();
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
